// File: rtl/uart_pkg.sv
// uart_pkg: byte width and launch-sequencer state encoding shared by the UART TX queue.
package uart_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_ACT  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GUARD     = 3'd4
  } txq_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: DEPTH x W byte queue with occupancy level, registered flags and registered pop data.
// With UART_TXQ_LEVEL_EN defined it also exports its level and a registered almost-full flag.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = BYTE_W,
`ifdef UART_TXQ_LEVEL_EN
  parameter int AFULL_LVL = 12,
`endif
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
`ifdef UART_TXQ_LEVEL_EN
  ,
  output logic [AW:0]  level,
  output logic         afull
`endif
);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   lvl, lvl_nxt;
  logic          do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    lvl_nxt = lvl;
    case ({do_push, do_pop})
      2'b10:   lvl_nxt = lvl + LVL_ONE;
      2'b01:   lvl_nxt = lvl - LVL_ONE;
      default: lvl_nxt = lvl;
    endcase
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        pop_data <= mem[rd_ptr];
      end
      lvl   <= lvl_nxt;
      full  <= (lvl_nxt == LVL_FULL);
      empty <= (lvl_nxt == '0);
    end
  end

`ifdef UART_TXQ_LEVEL_EN
  localparam logic [AW:0] LVL_AF = (AW+1)'(AFULL_LVL);

  assign level = lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) afull <= 1'b0;
    else        afull <= (lvl_nxt >= LVL_AF);
  end
`endif
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: host byte queue feeding UART_TX one frame at a time via 1-cycle launch pulses.
// Define UART_TXQ_LEVEL_EN to add the o_Level / o_Almost_Full occupancy outputs.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_Wr_DV,
  input  logic [BYTE_W-1:0] i_Wr_Byte,
  output logic              o_Wr_Ready,
  input  logic              i_Clr_Ovf,
  output logic              o_Overflow,
  output logic              o_Empty,
  output logic              o_TX_DV,
  output logic [BYTE_W-1:0] o_TX_Byte,
  input  logic              i_TX_Active,
  input  logic              i_TX_Done
`ifdef UART_TXQ_LEVEL_EN
  ,
  output logic [AW:0]       o_Level,
  output logic              o_Almost_Full
`endif
);
  if (DEPTH < 2 || (1 << AW) != DEPTH || AFULL_LVL > DEPTH) begin : g_bad_cfg
    $error("uart_tx_queue: DEPTH must be a power of two >= 2 and AFULL_LVL <= DEPTH");
  end

  txq_state_e state;
  logic       full, empty, pop;

  // The head is popped on the same edge that raises o_TX_DV, so o_TX_Byte is the fifo's pop register.
  assign pop        = (state == ST_IDLE) && !empty;
  assign o_Wr_Ready = !full;
  assign o_Empty    = empty;

  uart_sync_fifo #(
    .DEPTH(DEPTH),
`ifdef UART_TXQ_LEVEL_EN
    .AFULL_LVL(AFULL_LVL),
`endif
    .W(BYTE_W)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (i_Wr_DV),
    .push_data(i_Wr_Byte),
    .pop      (pop),
    .pop_data (o_TX_Byte),
    .full     (full),
    .empty    (empty)
`ifdef UART_TXQ_LEVEL_EN
    ,
    .level    (o_Level),
    .afull    (o_Almost_Full)
`endif
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      o_TX_DV <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            o_TX_DV <= 1'b1;
            state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          o_TX_DV <= 1'b0;
          state   <= ST_WAIT_ACT;
        end
        // A Done before any Active (very short frame) still closes the frame.
        ST_WAIT_ACT: begin
          if (i_TX_Done)        state <= ST_GUARD;
          else if (i_TX_Active) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (i_TX_Done) state <= ST_GUARD;
        ST_GUARD:     state <= ST_IDLE;
        default: begin
          o_TX_DV <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                  o_Overflow <= 1'b0;
    else if (i_Wr_DV && full)    o_Overflow <= 1'b1;
    else if (i_Clr_Ovf)          o_Overflow <= 1'b0;
  end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: random-timed UART_TX stand-in plus a queue/launch reference model for uart_tx_queue.
`timescale 1ns/1ps
module tb_uart_tx_queue;
  localparam int DEPTH     = 16;
  localparam int AFULL_LVL = 12;
  localparam int AW        = 4;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       i_Wr_DV = 1'b0, i_Clr_Ovf = 1'b0, i_TX_Active = 1'b0, i_TX_Done = 1'b0;
  logic [7:0] i_Wr_Byte = 8'h00;
  logic       o_Wr_Ready, o_Overflow, o_Empty, o_TX_DV;
  logic [7:0] o_TX_Byte;
`ifdef UART_TXQ_LEVEL_EN
  logic [AW:0] o_Level;
  logic        o_Almost_Full;
`endif

  uart_tx_queue #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .i_Wr_DV(i_Wr_DV), .i_Wr_Byte(i_Wr_Byte), .o_Wr_Ready(o_Wr_Ready),
    .i_Clr_Ovf(i_Clr_Ovf), .o_Overflow(o_Overflow), .o_Empty(o_Empty),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
    .i_TX_Active(i_TX_Active), .i_TX_Done(i_TX_Done)
`ifdef UART_TXQ_LEVEL_EN
    , .o_Level(o_Level), .o_Almost_Full(o_Almost_Full)
`endif
  );

  always #20 CLK = ~CLK;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Inputs as the DUT saw them at the last rising edge.
  int         cyc = 0;
  logic       wr_s = 1'b0, clr_s = 1'b0, done_s = 1'b0;
  logic [7:0] wrb_s = 8'h00;
  always @(posedge CLK) begin
    cyc    <= cyc + 1;
    wr_s   <= i_Wr_DV & RST_N;
    wrb_s  <= i_Wr_Byte;
    clr_s  <= i_Clr_Ovf & RST_N;
    done_s <= i_TX_Done & RST_N;
  end

  // Reference model: byte queue, one frame in flight, one idle cycle after Done.
  byte unsigned exp_q[$];
  byte unsigned rx_log[$];
  bit           m_busy = 0, m_guard = 0, m_ovf = 0;
  logic [7:0]   m_last = 8'h00;
  int           launches = 0;
  int           done_cyc = 0;
  bit           done_pend = 0;

  task automatic model_reset();
    exp_q.delete();
    m_busy = 0; m_guard = 0; m_ovf = 0; m_last = 8'h00; done_pend = 0;
  endtask

  initial begin : monitor
    int lvl;
    bit exp_dv, pre_busy;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        model_reset();
      end else begin
        lvl      = exp_q.size();
        pre_busy = m_busy;
        exp_dv   = !m_busy && !m_guard && lvl > 0;
        m_guard  = pre_busy && done_s;
        m_busy   = exp_dv || (pre_busy && !done_s);
        chk("tx_dv", o_TX_DV, exp_dv);
        if (exp_dv) begin
          m_last = exp_q.pop_front();
          rx_log.push_back(o_TX_Byte);
          launches++;
          if (done_pend) chk("dv_2_edges_after_done", cyc - done_cyc, 3);
          done_pend = 0;
        end
        chk("tx_byte", o_TX_Byte, m_last);
        if (wr_s && lvl < DEPTH) exp_q.push_back(wrb_s);
        if (wr_s && lvl == DEPTH) m_ovf = 1;
        else if (clr_s)           m_ovf = 0;
        chk("wr_ready", o_Wr_Ready, exp_q.size() < DEPTH);
        chk("empty", o_Empty, exp_q.size() == 0);
        chk("overflow", o_Overflow, m_ovf);
`ifdef UART_TXQ_LEVEL_EN
        chk("level", o_Level, exp_q.size());
        chk("almost_full", o_Almost_Full, exp_q.size() >= AFULL_LVL);
`endif
      end
    end
  end

  // UART_TX stand-in: random Active delay, random frame length, optional hold, optional missing Active.
  bit hold_tx = 0, tx_abort = 0;
  task automatic tx_step();
    @(negedge CLK);
    if (!RST_N) tx_abort = 1;
  endtask

  initial begin : uart_model
    forever begin
      @(negedge CLK);
      i_TX_Active = 0; i_TX_Done = 0;
      if (RST_N && o_TX_DV) begin : frame
        int act_dly, len;
        bit no_act;
        tx_abort = 0;
        act_dly  = $urandom_range(1, 3);
        len      = $urandom_range(3, 12);
        no_act   = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < act_dly && !tx_abort; i++) tx_step();
        if (!tx_abort && !no_act) i_TX_Active = 1;
        for (int i = 0; i < len && !tx_abort; i++) tx_step();
        for (int i = 0; i < 5000 && hold_tx && !tx_abort; i++) tx_step();
        if (!tx_abort) begin
          i_TX_Active = 0; i_TX_Done = 1;
          done_cyc  = cyc;
          done_pend = (exp_q.size() > 0);
          tx_step();
        end
        i_TX_Active = 0; i_TX_Done = 0;
      end
    end
  end

  task automatic tick();
    @(negedge CLK); #1;
  endtask

  task automatic wr(input logic [7:0] b);
    i_Wr_DV = 1; i_Wr_Byte = b;
    tick();
    i_Wr_DV = 0;
  endtask

  task automatic wait_launch(input string tag);
    int n, k;
    n = launches;
    for (k = 0; k < 2000 && launches == n; k++) tick();
    chk({tag, "_launch_timeout"}, launches != n, 1);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    for (k = 0; k < 4000; k++) begin
      if (exp_q.size() == 0 && !m_busy && !m_guard) break;
      tick();
    end
    chk({tag, "_drain_timeout"}, k < 4000, 1);
  endtask

  task automatic chk_rx(input string tag, input byte unsigned exp[$]);
    chk({tag, "_rx_count"}, rx_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_log.size(); i++)
      chk({tag, "_rx_order"}, rx_log[i], exp[i]);
  endtask

  initial begin : stim
    byte unsigned e[$];
    int n, w;
    repeat (3) tick();
    chk("rst_ready", o_Wr_Ready, 1);
    chk("rst_empty", o_Empty, 1);
    chk("rst_dv", o_TX_DV, 0);
    chk("rst_byte", o_TX_Byte, 8'h00);
    chk("rst_ovf", o_Overflow, 0);
    #4 RST_N = 1;
    tick();

    // single byte, launch one edge after the write edge
    rx_log.delete();
    wr(8'h3A);
    chk("t1_dv_early", o_TX_DV, 0);
    tick();
    chk("t1_dv", o_TX_DV, 1);
    chk("t1_byte", o_TX_Byte, 8'h3A);
    chk("t1_empty", o_Empty, 1);
    wait_drain("t1");
    e = '{8'h3A}; chk_rx("t1", e);

    // back-to-back frames
    rx_log.delete();
    wr(8'h11); wr(8'h22); wr(8'h33);
    wait_drain("t2");
    e = '{8'h11, 8'h22, 8'h33}; chk_rx("t2", e);

    // fill while TX busy, overflow beats a same-edge clear
    rx_log.delete();
    hold_tx = 1;
    wr(8'hEE);
    wait_launch("t3");
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("t3_ready_full", o_Wr_Ready, 0);
    i_Clr_Ovf = 1;
    wr(8'h10);
    i_Clr_Ovf = 0;
    chk("t3_ovf_set", o_Overflow, 1);
    i_Clr_Ovf = 1; tick(); i_Clr_Ovf = 0;
    chk("t3_ovf_clr", o_Overflow, 0);
    hold_tx = 0;
    wait_drain("t3");
    e = '{8'hEE};
    for (int i = 0; i < 16; i++) e.push_back(8'(i));
    chk_rx("t3", e);

    // writes held on while full across pop edges
    hold_tx = 1;
    wr(8'hA5);
    wait_launch("t3b");
    for (int i = 0; i < 16; i++) wr(8'($urandom));
    hold_tx = 0;
    i_Wr_DV = 1;
    for (int i = 0; i < 60; i++) begin
      i_Wr_Byte = 8'($urandom);
      tick();
    end
    i_Wr_DV = 0;
    chk("t3b_ovf", o_Overflow, 1);
    i_Clr_Ovf = 1; tick(); i_Clr_Ovf = 0;
    wait_drain("t3b");

    // 40-byte stream with random gaps, wraps pointers
    rx_log.delete();
    e.delete();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      for (w = 0; w < 3000 && !o_Wr_Ready; w++) tick();
      chk("t4_ready_timeout", w < 3000, 1);
      wr(8'(i));
      e.push_back(8'(i));
    end
    wait_drain("t4");
    chk_rx("t4", e);

    // reset mid-frame with bytes queued
    hold_tx = 1;
    wr(8'h55);
    wait_launch("t5");
    wr(8'h01); wr(8'h02); wr(8'h03);
    #4 RST_N = 0;
    #1;
    chk("t5_rst_dv", o_TX_DV, 0);
    chk("t5_rst_byte", o_TX_Byte, 8'h00);
    chk("t5_rst_ready", o_Wr_Ready, 1);
    chk("t5_rst_empty", o_Empty, 1);
    chk("t5_rst_ovf", o_Overflow, 0);
    hold_tx = 0;
    tick();
    #4 RST_N = 1;
    n = launches;
    repeat (20) tick();
    chk("t5_no_dv_after_rst", launches - n, 0);
    rx_log.delete();
    wr(8'h77);
    wait_drain("t5");
    e = '{8'h77}; chk_rx("t5", e);

`ifdef UART_TXQ_LEVEL_EN
    hold_tx = 1;
    wr(8'hC3);
    wait_launch("t6");
    for (int i = 0; i < 12; i++) wr(8'(8'h40 + i));
    chk("t6_level12", o_Level, 12);
    chk("t6_af_set", o_Almost_Full, 1);
    hold_tx = 0;
    wait_launch("t6");
    chk("t6_level11", o_Level, 11);
    chk("t6_af_clr", o_Almost_Full, 0);
    wait_drain("t6");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
